sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 22, byte-address width (SRAM word address = ADDR_W-2 bits).
REQ-002 SHALL provide parameter RD_WAIT, default 1, extra read-strobe cycles (0..15).
REQ-003 SHALL provide parameter WR_WAIT, default 1, extra write-pulse cycles (0..15).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  request strobe, sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read.
REQ-008 size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 sext  input  1  sign-extend byte/half reads when 1, else zero-extend.
REQ-010 addr  input  ADDR_W  byte address.
REQ-011 wdata  input  32  write data, right-aligned.
REQ-012 rdata  output  32  read data, extended and right-aligned.
REQ-013 ack  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse with ack on rejected request.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 ram_data  inout  32  SRAM data bus.
REQ-017 ram_addr  output  ADDR_W-2  SRAM word address = addr[ADDR_W-1:2].
REQ-018 ram_be_n  output  4  byte enables, active-low.
REQ-019 ram_ce_n / ram_oe_n / ram_we_n  output  1 each  chip select, output enable, write enable, active-low.

Function
REQ-020 All outputs SHALL be driven from flops; ram_data SHALL be tri-stated except in WR_SETUP, WR_PULSE, WR_HOLD.
REQ-021 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, ERR.
REQ-022 In IDLE with req=1, addr/we/size/sext/wdata SHALL be captured at that edge (cycle 0); req while busy SHALL be ignored.
REQ-023 Alignment: half requires addr[0]=0, word requires addr[1:0]=00; misaligned or size=11 SHALL go to ERR with no SRAM pin activity.
REQ-024 ERR SHALL last 1 cycle (cycle 1) with ack=1, err=1, then IDLE.
REQ-025 Read: RD for cycles 1..RD_WAIT+1 with ce_n=0, oe_n=0, we_n=1; ram_data sampled at the last RD edge; DONE in cycle RD_WAIT+2.
REQ-026 Write: WR_SETUP cycle 1 (ce_n=0, we_n=1, data driven); WR_PULSE cycles 2..WR_WAIT+2 (we_n=0); WR_HOLD cycle WR_WAIT+3 (we_n=1, data still driven); DONE cycle WR_WAIT+4.
REQ-027 DONE SHALL assert ack=1, err=0, deassert all strobes, return to IDLE next cycle; earliest next accept is the cycle after DONE.
REQ-028 Byte lanes: byte be_n = ~(0001<<addr[1:0]); half be_n = addr[1]?0011:1100; word be_n = 0000.
REQ-029 Write data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-030 Read data SHALL be extracted from the enabled lane(s) and extended per sext; rdata SHALL hold until the next successful read's DONE.
REQ-031 Inactive pins: ce_n=oe_n=we_n=1, be_n=1111; ram_addr SHALL hold its last value.

Reset
REQ-032 On rst_n=0, asynchronously and in any state: FSM=IDLE, ram_data=Z, ce_n=oe_n=we_n=1, be_n=1111, ram_addr=0, rdata=0, ack=err=busy=0; an interrupted access SHALL produce no ack after release.
REQ-033 First request SHALL be accepted at the first rising edge with rst_n=1 and req=1.

Verification (RD_WAIT=1, WR_WAIT=1)
REQ-034 Word write addr 0x000010, wdata 0xDEADBEEF -> ram_addr 0x00004, be_n 0000, we_n low cycles 2-3, ram_data Z at cycle 5, ack cycle 5.
REQ-035 Byte read sext=1 addr 0x000013, SRAM returns 0x80112233 -> be_n 0111, oe_n low cycles 1-2, rdata 0xFFFFFF80, ack cycle 3; sext=0 gives 0x00000080.
REQ-036 Half write addr 0x000006, wdata 0x0000A5C3 -> be_n 0011, ram_data 0xA5C3A5C3 cycles 1-4.
REQ-037 Word read addr 0x000002 -> ack=err=1 cycle 1, ce_n stays 1 throughout.
REQ-038 rst_n low during WR_PULSE -> we_n=1 and ram_data Z before next edge, no ack after release; new read then completes normally.
REQ-039 req held high through a write -> exactly one access, second accept only after DONE, busy low only in IDLE.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle for sram_ctrl.
// The master drives a request; the slave (controller) returns data and status.
interface sram_ctrl_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: byte/half/word accesses with programmable strobe widths.
// Every output, including the ram_data drive enable, comes straight from a flop.
module sram_ctrl #(
    parameter int unsigned ADDR_W  = 22,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    inout  wire  [31:0]       ram_data,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [2:0] {
        StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StDone, StErr
    } state_e;

    state_e             r_state, w_state_d;
    logic [3:0]         r_cnt, w_cnt_d;
    logic [1:0]         r_size, w_size_d;
    logic               r_sext, w_sext_d;
    logic [1:0]         r_lane, w_lane_d;
    logic [31:0]        r_wdata, w_wdata_d;
    logic [3:0]         r_be_sel, w_be_sel_d;
    logic [ADDR_W-3:0]  r_ram_addr, w_ram_addr_d;
    logic [31:0]        r_rdata, w_rdata_d;
    logic               r_ack, w_ack_d;
    logic               r_err, w_err_d;
    logic               r_busy, w_busy_d;
    logic               r_ce_n, w_ce_n_d;
    logic               r_oe_n, w_oe_n_d;
    logic               r_we_n, w_we_n_d;
    logic [3:0]         r_be_n, w_be_n_d;
    logic               r_dq_oe, w_dq_oe_d;

    logic               w_bad;
    logic [3:0]         w_be_req;
    logic [31:0]        w_wrep;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [31:0]        w_rd_ext;

    // Request decode: alignment, lane mask and write-data replication.
    always_comb begin
        w_bad    = 1'b0;
        w_be_req = 4'b0000;
        w_wrep   = bus.wdata;
        case (bus.size)
            2'b00: begin
                w_be_req = ~(4'b0001 << bus.addr[1:0]);
                w_wrep   = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                w_bad    = bus.addr[0];
                w_be_req = bus.addr[1] ? 4'b0011 : 4'b1100;
                w_wrep   = {2{bus.wdata[15:0]}};
            end
            2'b10:   w_bad = (bus.addr[1:0] != 2'b00);
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_byte = ram_data[{r_lane, 3'b000} +: 8];
        w_rd_half = r_lane[1] ? ram_data[31:16] : ram_data[15:0];
        case (r_size)
            2'b00:   w_rd_ext = {{24{r_sext & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_rd_ext = {{16{r_sext & w_rd_half[15]}}, w_rd_half};
            default: w_rd_ext = ram_data;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_size_d     = r_size;
        w_sext_d     = r_sext;
        w_lane_d     = r_lane;
        w_wdata_d    = r_wdata;
        w_be_sel_d   = r_be_sel;
        w_ram_addr_d = r_ram_addr;
        w_rdata_d    = r_rdata;

        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    w_size_d   = bus.size;
                    w_sext_d   = bus.sext;
                    w_lane_d   = bus.addr[1:0];
                    w_wdata_d  = w_wrep;
                    w_be_sel_d = w_be_req;
                    if (w_bad) begin
                        w_state_d = StErr;
                    end else begin
                        w_ram_addr_d = bus.addr[ADDR_W-1:2];
                        w_cnt_d      = 4'd0;
                        w_state_d    = bus.we ? StWrSetup : StRd;
                    end
                end
            end
            StRd: begin
                if (r_cnt == 4'(RD_WAIT)) begin
                    w_state_d = StDone;
                    w_rdata_d = w_rd_ext;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StWrSetup: begin
                w_state_d = StWrPulse;
                w_cnt_d   = 4'd0;
            end
            StWrPulse: begin
                if (r_cnt == 4'(WR_WAIT)) w_state_d = StWrHold;
                else                      w_cnt_d   = r_cnt + 4'd1;
            end
            StWrHold: w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            StErr:    w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase

        // Pin/status values are decoded from the next state so they launch from flops.
        w_ce_n_d  = !(w_state_d inside {StRd, StWrSetup, StWrPulse, StWrHold});
        w_oe_n_d  = (w_state_d != StRd);
        w_we_n_d  = (w_state_d != StWrPulse);
        w_dq_oe_d = (w_state_d inside {StWrSetup, StWrPulse, StWrHold});
        w_be_n_d  = w_ce_n_d ? 4'b1111 : w_be_sel_d;
        w_ack_d   = (w_state_d inside {StDone, StErr});
        w_err_d   = (w_state_d == StErr);
        w_busy_d  = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= 32'd0;
            r_be_sel   <= 4'b1111;
            r_ram_addr <= '0;
            r_rdata    <= 32'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_be_n     <= 4'b1111;
            r_dq_oe    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_size     <= w_size_d;
            r_sext     <= w_sext_d;
            r_lane     <= w_lane_d;
            r_wdata    <= w_wdata_d;
            r_be_sel   <= w_be_sel_d;
            r_ram_addr <= w_ram_addr_d;
            r_rdata    <= w_rdata_d;
            r_ack      <= w_ack_d;
            r_err      <= w_err_d;
            r_busy     <= w_busy_d;
            r_ce_n     <= w_ce_n_d;
            r_oe_n     <= w_oe_n_d;
            r_we_n     <= w_we_n_d;
            r_be_n     <= w_be_n_d;
            r_dq_oe    <= w_dq_oe_d;
        end
    end

    assign ram_data  = r_dq_oe ? r_wdata : 32'hzzzz_zzzz;
    assign ram_addr  = r_ram_addr;
    assign ram_be_n  = r_be_n;
    assign ram_ce_n  = r_ce_n;
    assign ram_oe_n  = r_oe_n;
    assign ram_we_n  = r_we_n;
    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with RD_WAIT=WR_WAIT=1: vector table plus reset and
// back-to-back request sequences. Cycle k means the k-th cycle after the accepting edge.
module tb_sram_ctrl;
    localparam int unsigned ADDR_W = 22;
    localparam int KRd = 0, KWr = 1, KErr = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic        tb_drv_en = 1'b0;
    logic [31:0] tb_drv_val = 32'd0;

    assign ram_data = tb_drv_en ? tb_drv_val : 32'hzzzz_zzzz;

    sram_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

    sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(1), .WR_WAIT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_be_n (ram_be_n),
        .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Per-cycle trace: bit/index k holds the value observed in cycle k.
    logic [15:0] m_ce, m_oe, m_we, m_dq, m_ack, m_err, m_busy;
    logic [3:0]  a_be    [16];
    logic [19:0] a_addr  [16];
    logic [31:0] a_rdata [16];
    logic [31:0] a_bus   [16];

    typedef struct {
        int          kind;
        logic [1:0]  size;
        logic        sext;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [31:0] sram;
        logic [3:0]  be_n;
        logic [19:0] raddr;
        logic [31:0] rdata;
        logic [31:0] wbus;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int k);
        m_ce[k]    = !ram_ce_n;
        m_oe[k]    = !ram_oe_n;
        m_we[k]    = !ram_we_n;
        m_dq[k]    = dut.r_dq_oe;
        m_ack[k]   = bus_if.ack;
        m_err[k]   = bus_if.err;
        m_busy[k]  = bus_if.busy;
        a_be[k]    = ram_be_n;
        a_addr[k]  = ram_addr;
        a_rdata[k] = bus_if.rdata;
        a_bus[k]   = ram_data;
    endtask

    task automatic capture(input int n);
        m_ce = '0; m_oe = '0; m_we = '0; m_dq = '0; m_ack = '0; m_err = '0; m_busy = '0;
        for (int k = 1; k <= n; k++) begin
            sample(k);
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic start(input logic we, input logic [1:0] size, input logic sext,
                         input logic [21:0] addr, input logic [31:0] wdata,
                         input logic [31:0] sram);
        bus_if.we    = we;
        bus_if.size  = size;
        bus_if.sext  = sext;
        bus_if.addr  = addr;
        bus_if.wdata = wdata;
        tb_drv_en    = !we;
        tb_drv_val   = sram;
        bus_if.req   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] e_ack, e_ce, e_oe, e_we, e_dq, e_busy;
        int          ac;

        //        kind  size   sx addr        wdata         sram          be_n     raddr     rdata         wbus
        vecs[0]  = '{KWr,  2'b10, 0, 22'h000010, 32'hDEADBEEF, 32'h0,        4'b0000, 20'h00004, 32'h00000000, 32'hDEADBEEF};
        vecs[1]  = '{KRd,  2'b00, 1, 22'h000013, 32'h0,        32'h80112233, 4'b0111, 20'h00004, 32'hFFFFFF80, 32'h0};
        vecs[2]  = '{KRd,  2'b00, 0, 22'h000013, 32'h0,        32'h80112233, 4'b0111, 20'h00004, 32'h00000080, 32'h0};
        vecs[3]  = '{KWr,  2'b01, 0, 22'h000006, 32'h0000A5C3, 32'h0,        4'b0011, 20'h00001, 32'h00000080, 32'hA5C3A5C3};
        vecs[4]  = '{KErr, 2'b10, 0, 22'h000002, 32'h0,        32'hFFFFFFFF, 4'b1111, 20'h00001, 32'h00000080, 32'h0};
        vecs[5]  = '{KRd,  2'b01, 1, 22'h000004, 32'h0,        32'h1234F00D, 4'b1100, 20'h00001, 32'hFFFFF00D, 32'h0};
        vecs[6]  = '{KRd,  2'b01, 0, 22'h000022, 32'h0,        32'h9ABC5678, 4'b0011, 20'h00008, 32'h00009ABC, 32'h0};
        vecs[7]  = '{KWr,  2'b00, 0, 22'h000101, 32'h0000007E, 32'h0,        4'b1101, 20'h00040, 32'h00009ABC, 32'h7E7E7E7E};
        vecs[8]  = '{KErr, 2'b11, 0, 22'h000000, 32'h0,        32'h0,        4'b1111, 20'h00040, 32'h00009ABC, 32'h0};
        vecs[9]  = '{KErr, 2'b01, 0, 22'h000005, 32'h0,        32'h0,        4'b1111, 20'h00040, 32'h00009ABC, 32'h0};
        vecs[10] = '{KRd,  2'b10, 0, 22'h3FFFFC, 32'h0,        32'hCAFEF00D, 4'b0000, 20'hFFFFF, 32'hCAFEF00D, 32'h0};
        vecs[11] = '{KRd,  2'b00, 1, 22'h000001, 32'h0,        32'h00007F00, 4'b1101, 20'h00000, 32'h0000007F, 32'h0};

        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.size = 2'b00; bus_if.sext = 1'b0;
        bus_if.addr = '0; bus_if.wdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        sample(1);
        chk("reset ce_n", 32'(ram_ce_n), 32'd1);
        chk("reset oe_n", 32'(ram_oe_n), 32'd1);
        chk("reset we_n", 32'(ram_we_n), 32'd1);
        chk("reset be_n", 32'(ram_be_n), 32'hF);
        chk("reset ram_addr", 32'(ram_addr), 32'd0);
        chk("reset rdata", bus_if.rdata, 32'd0);
        chk("reset ack/err/busy", {29'd0, bus_if.ack, bus_if.err, bus_if.busy}, 32'd0);
        chk("reset dq_oe", 32'(dut.r_dq_oe), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].kind == KWr, vecs[i].size, vecs[i].sext, vecs[i].addr,
                  vecs[i].wdata, vecs[i].sram);
            capture(8);
            case (vecs[i].kind)
                KRd: begin
                    ac = 3; e_ack = 16'h0008; e_ce = 16'h0006; e_oe = 16'h0006;
                    e_we = 16'h0000; e_dq = 16'h0000; e_busy = 16'h000E;
                end
                KWr: begin
                    ac = 5; e_ack = 16'h0020; e_ce = 16'h001E; e_oe = 16'h0000;
                    e_we = 16'h000C; e_dq = 16'h001E; e_busy = 16'h003E;
                end
                default: begin
                    ac = 1; e_ack = 16'h0002; e_ce = 16'h0000; e_oe = 16'h0000;
                    e_we = 16'h0000; e_dq = 16'h0000; e_busy = 16'h0002;
                end
            endcase
            chk($sformatf("v%0d ack cycles", i), 32'(m_ack), 32'(e_ack));
            chk($sformatf("v%0d err cycles", i), 32'(m_err),
                (vecs[i].kind == KErr) ? 32'(e_ack) : 32'd0);
            chk($sformatf("v%0d busy cycles", i), 32'(m_busy), 32'(e_busy));
            chk($sformatf("v%0d ce_n low cycles", i), 32'(m_ce), 32'(e_ce));
            chk($sformatf("v%0d oe_n low cycles", i), 32'(m_oe), 32'(e_oe));
            chk($sformatf("v%0d we_n low cycles", i), 32'(m_we), 32'(e_we));
            chk($sformatf("v%0d data drive cycles", i), 32'(m_dq), 32'(e_dq));
            chk($sformatf("v%0d be_n", i), 32'(a_be[1]), 32'(vecs[i].be_n));
            chk($sformatf("v%0d be_n at ack", i), 32'(a_be[ac]), 32'hF);
            chk($sformatf("v%0d ram_addr", i), 32'(a_addr[1]), 32'(vecs[i].raddr));
            chk($sformatf("v%0d rdata at ack", i), a_rdata[ac], vecs[i].rdata);
            chk($sformatf("v%0d rdata held", i), a_rdata[8], vecs[i].rdata);
            if (vecs[i].kind == KWr) begin
                chk($sformatf("v%0d ram_data setup", i), a_bus[1], vecs[i].wbus);
                chk($sformatf("v%0d ram_data hold", i), a_bus[4], vecs[i].wbus);
            end
        end

        // req held high: one access per request, re-accept only after DONE.
        bus_if.we = 1'b1; bus_if.size = 2'b10; bus_if.sext = 1'b0;
        bus_if.addr = 22'h000020; bus_if.wdata = 32'h0BADF00D; tb_drv_en = 1'b0;
        bus_if.req = 1'b1;
        @(posedge clk);
        #1;
        capture(12);
        bus_if.req = 1'b0;
        chk("held req ack cycles", 32'(m_ack), 32'h0820);
        chk("held req busy cycles", 32'(m_busy), 32'h0FBE);
        chk("held req ce_n low cycles", 32'(m_ce), 32'h079E);
        chk("held req ram_addr", 32'(a_addr[7]), 32'h00008);
        repeat (3) @(posedge clk);
        #1;

        // Reset asserted mid write pulse.
        start(1'b1, 2'b10, 1'b0, 22'h000040, 32'h55AA55AA, 32'h0);
        @(posedge clk);
        #1;
        chk("pre-reset we_n low", 32'(ram_we_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset we_n", 32'(ram_we_n), 32'd1);
        chk("async reset dq_oe", 32'(dut.r_dq_oe), 32'd0);
        chk("async reset ce_n", 32'(ram_ce_n), 32'd1);
        chk("async reset be_n", 32'(ram_be_n), 32'hF);
        chk("async reset ram_addr", 32'(ram_addr), 32'd0);
        chk("async reset rdata", bus_if.rdata, 32'd0);
        chk("async reset busy", 32'(bus_if.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        capture(8);
        chk("post-reset ack", 32'(m_ack), 32'd0);
        chk("post-reset busy", 32'(m_busy), 32'd0);
        chk("post-reset ce_n low cycles", 32'(m_ce), 32'd0);

        start(1'b0, 2'b10, 1'b0, 22'h000008, 32'h0, 32'h11223344);
        capture(8);
        chk("post-reset read ack cycles", 32'(m_ack), 32'h0008);
        chk("post-reset read rdata", a_rdata[3], 32'h11223344);
        chk("post-reset read ram_addr", 32'(a_addr[1]), 32'h00002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
